mem_access_unit: RTL

- Load/store front-end of the MEM stage; sits between the EX/MEM pipeline register and data_memory.
- data_memory is word-only: byte address in, internal >>2, one 32-bit write-enable.
- This block converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses:
  - two-cycle read-modify-write (RMW) for sub-word stores;
  - lane extraction and sign/zero extension for loads;
  - misaligned, out-of-range and illegal-access flagging.
- Registered response feeds MEM/WB.

---
 rtl/mem_access_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store front-end of the MEM stage: turns RV32I byte/half/word accesses
// into word-only data_memory cycles, with sub-word stores done as read-modify-write.
module mem_access_unit #(
   parameter int unsigned DEPTH = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        exc_misaligned,
   output logic        exc_fault,
   output logic        exc_illegal,
   output logic [31:0] exc_addr
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned WIDXW = 30;
   localparam int unsigned HALFW = 16;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic {
      IDLE  = 1'b0,
      MERGE = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   buf_q, buf_d;
   logic [XLEN-1:0]   hold_addr_q, hold_addr_d;
   logic [HALFW-1:0]  hold_data_q, hold_data_d;
   logic              hold_half_q, hold_half_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
   logic              exc_mis_q, exc_mis_d;
   logic              exc_fault_q, exc_fault_d;
   logic              exc_ill_q, exc_ill_d;
   logic [XLEN-1:0]   exc_addr_q, exc_addr_d;

   logic              is_access, is_half, is_word;
   logic              cls_illegal, cls_misaligned, cls_fault;
   logic [XLEN-1:0]   word_addr;
   logic [7:0]        ld_byte;
   logic [HALFW-1:0]  ld_half;
   logic [XLEN-1:0]   load_ext;
   logic [XLEN-1:0]   merge_word;

   // Request classification, evaluated only when a new request is taken in IDLE
   always_comb begin
      is_access      = req_read | req_write;
      is_half        = (req_funct3 == F3_H) || (req_funct3 == F3_HU);
      is_word        = (req_funct3 == F3_W);
      cls_illegal    = (req_read && req_write)
                     || (req_read && ((req_funct3 == 3'd3) || (req_funct3 == 3'd6)
                                      || (req_funct3 == 3'd7)))
                     || (req_write && (req_funct3 > F3_W));
      cls_misaligned = is_access && ((is_half && req_addr[0])
                                     || (is_word && (req_addr[1:0] != 2'b00)));
      cls_fault      = is_access && (req_addr[31:2] >= WIDXW'(DEPTH));
      word_addr      = {req_addr[31:2], 2'b00};
   end

   // Load lane extraction and sign/zero extension
   always_comb begin
      ld_byte  = mem_rdata[7:0];
      ld_half  = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_ext = mem_rdata;
      case (req_addr[1:0])
         2'd0:    ld_byte = mem_rdata[7:0];
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      case (req_funct3)
         F3_B:    load_ext = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   load_ext = {24'h000000, ld_byte};
         F3_H:    load_ext = {{16{ld_half[15]}}, ld_half};
         F3_HU:   load_ext = {16'h0000, ld_half};
         default: load_ext = mem_rdata;
      endcase
   end

   // Sub-word lane replacement on the captured word
   always_comb begin
      merge_word = buf_q;
      if (hold_half_q) begin
         if (hold_addr_q[1]) merge_word[31:16] = hold_data_q;
         else                merge_word[15:0]  = hold_data_q;
      end else begin
         case (hold_addr_q[1:0])
            2'd0:    merge_word[7:0]   = hold_data_q[7:0];
            2'd1:    merge_word[15:8]  = hold_data_q[7:0];
            2'd2:    merge_word[23:16] = hold_data_q[7:0];
            default: merge_word[31:24] = hold_data_q[7:0];
         endcase
      end
   end

   // Next-state, memory strobes and response/exception staging
   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      hold_addr_d = hold_addr_q;
      hold_data_d = hold_data_q;
      hold_half_d = hold_half_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      exc_mis_d   = 1'b0;
      exc_fault_d = 1'b0;
      exc_ill_d   = 1'b0;
      exc_addr_d  = exc_addr_q;
      stall       = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (cls_illegal) begin
                  exc_ill_d  = 1'b1;
                  exc_addr_d = req_addr;
               end else if (cls_misaligned) begin
                  exc_mis_d  = 1'b1;
                  exc_addr_d = req_addr;
               end else if (cls_fault) begin
                  exc_fault_d = 1'b1;
                  exc_addr_d  = req_addr;
               end else if (req_read) begin
                  mem_read    = 1'b1;
                  mem_addr    = word_addr;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = load_ext;
               end else if (req_write) begin
                  mem_addr = word_addr;
                  if (is_word) begin
                     mem_write = 1'b1;
                     mem_wdata = req_wdata;
                  end else begin
                     // First half of RMW: fetch the word, write it back next cycle
                     mem_read    = 1'b1;
                     stall       = 1'b1;
                     buf_d       = mem_rdata;
                     hold_addr_d = req_addr;
                     hold_data_d = req_wdata[15:0];
                     hold_half_d = (req_funct3 == F3_H);
                     state_d     = MERGE;
                  end
               end
            end
         end
         MERGE: begin
            mem_write = 1'b1;
            mem_addr  = {hold_addr_q[31:2], 2'b00};
            mem_wdata = merge_word;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         buf_q       <= '0;
         hold_addr_q <= '0;
         hold_data_q <= '0;
         hold_half_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         exc_mis_q   <= 1'b0;
         exc_fault_q <= 1'b0;
         exc_ill_q   <= 1'b0;
         exc_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         hold_addr_q <= hold_addr_d;
         hold_data_q <= hold_data_d;
         hold_half_q <= hold_half_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         exc_mis_q   <= exc_mis_d;
         exc_fault_q <= exc_fault_d;
         exc_ill_q   <= exc_ill_d;
         exc_addr_q  <= exc_addr_d;
      end
   end

   assign rsp_valid      = rsp_valid_q;
   assign rsp_data       = rsp_data_q;
   assign exc_misaligned = exc_mis_q;
   assign exc_fault      = exc_fault_q;
   assign exc_illegal    = exc_ill_q;
   assign exc_addr       = exc_addr_q;

endmodule
